mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Two-requester arbiter that shares the single-port internal_mem (8-bit address, 16-bit word) between the CPU instruction-fetch path (port F) and the load/store path (port D). It sequences each access through a small FSM, drives the memory's enable/write strobes, and returns read data with a one-cycle valid pulse. It sits between the core's fetch/execute units and internal_mem.

Parameters:
ADDR_W, 8, memory address width
DATA_W, 16, memory word width
FIXED_PRIO, 0, 0 = round-robin on contention; 1 = port F always wins on contention

Ports:
clk  input  1  system clock, rising edge
rstN  input  1  asynchronous active-low reset
fReq  input  1  fetch request; held until fGnt
fAddr  input  ADDR_W  fetch address (read-only port)
fGnt  output  1  one-cycle grant pulse to fetch
fValid  output  1  one-cycle fetch read-data valid
fData  output  DATA_W  fetch read data, meaningful only when fValid=1
dReq  input  1  data request; held until dGnt
dWe  input  1  1 = write, 0 = read; held with dReq
dAddr  input  ADDR_W  data address
dWdata  input  DATA_W  write data
dGnt  output  1  one-cycle grant pulse to data port
dValid  output  1  one-cycle data read-data valid (reads only)
dData  output  DATA_W  data read data, meaningful only when dValid=1
memAddr  output  ADDR_W  to internal_mem addr
memEnable  output  1  to internal_mem enable
memWEnable  output  1  to internal_mem wEnable
memNewWord  output  DATA_W  to internal_mem newWord
memWordOut  input  DATA_W  from internal_mem wordOut; valid the cycle after a read issue

Behaviour:
- Reset (rstN=0, async): state=IDLE; all outputs 0 (memAddr, memNewWord, fData/dData drive 0); lastWin=D so F wins first contention.
- States: IDLE, ISSUE, RESP. All outputs except fData/dData are registered.
- IDLE: if no req, stay. Else select winner: only one req -> that port; both -> FIXED_PRIO=1 ? F : port != lastWin. Latch winner, addr, we, wdata; go ISSUE. Requests are sampled only in IDLE.
- ISSUE (1 cycle): memEnable=1, memAddr=latched addr, memWEnable=latched we (always 0 for F), memNewWord=latched wdata (0 for F); winner's Gnt=1; lastWin<=winner. Next: read -> RESP, write -> IDLE.
- RESP (1 cycle): memEnable=0, memWEnable=0; winner's Valid=1; fData/dData = memWordOut combinationally for the winner, 0 for the other port; next IDLE.
- Latency from req seen in IDLE at cycle 0: Gnt at cycle 1, Valid at cycle 2 (reads); next arbitration at cycle 3 (read) or cycle 2 (write). Max throughput: one read per 3 cycles, one write per 2.
- Requester may drop or change req/addr/data the cycle after Gnt; asserting a new req in that cycle is sampled at the next IDLE.
- Dropping req before Gnt is a protocol violation; the arbiter still completes an access it has latched.
- Only one of fGnt/dGnt and at most one of fValid/dValid is ever high; Gnt and Valid are never high simultaneously.
- Write completion: no Valid; memory updated at the end of ISSUE; a read of the same address granted afterwards returns the new word.
- Reset mid-access: outputs drop to 0 immediately; pending Valid is never issued; a write in ISSUE may or may not have committed (undefined).
- Address is not range-checked; full ADDR_W range is legal, no wrap logic.

Test Plan:
- Reset: hold rstN=0 3 cycles -> all outputs 0; release, no req -> stays IDLE, memEnable=0.
- Single fetch: fReq=1, fAddr=0 at cycle 0 -> fGnt=1, memEnable=1, memAddr=0 at cycle 1; fValid=1, fData=mem[0] at cycle 2.
- Write then read: dWe=1, dAddr=1, dWdata=50000 -> dGnt, memWEnable=1, memNewWord=50000 at cycle 1, no dValid; then dWe=0, dAddr=1 -> dValid with dData=50000.
- Contention round-robin (FIXED_PRIO=0): fReq and dReq held high continuously -> grants alternate F, D, F, D; first grant F.
- Fixed priority (FIXED_PRIO=1): both held high 4 accesses -> all grants to F, dGnt never asserted; drop fReq -> D granted on next IDLE.
- Reset mid-read: pull rstN low during ISSUE -> memEnable/fGnt drop immediately, no fValid after release, FSM in IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single-port internal_mem. Port F is a
// read-only fetch path and port D is the load/store path. Each access runs
// IDLE -> ISSUE -> RESP for reads and IDLE -> ISSUE for writes.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 16,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              fReq,
  input  logic [ADDR_W-1:0] fAddr,
  output logic              fGnt,
  output logic              fValid,
  output logic [DATA_W-1:0] fData,
  input  logic              dReq,
  input  logic              dWe,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWdata,
  output logic              dGnt,
  output logic              dValid,
  output logic [DATA_W-1:0] dData,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memEnable,
  output logic              memWEnable,
  output logic [DATA_W-1:0] memNewWord,
  input  logic [DATA_W-1:0] memWordOut
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic {
    PORT_F = 1'b0,
    PORT_D = 1'b1
  } port_t;

  state_t state;
  port_t  winner;
  port_t  last_win;
  port_t  pick_c;

  // Winner selection among the requests present this cycle
  always_comb begin
    pick_c = PORT_F;
    if (fReq && dReq) begin
      if (FIXED_PRIO) begin
        pick_c = PORT_F;
      end else begin
        pick_c = (last_win == PORT_F) ? PORT_D : PORT_F;
      end
    end else if (dReq) begin
      pick_c = PORT_D;
    end
  end

  // Access sequencer; memory strobes, grants and valids are all registered
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= IDLE;
      winner     <= PORT_F;
      last_win   <= PORT_D;
      fGnt       <= 1'b0;
      dGnt       <= 1'b0;
      fValid     <= 1'b0;
      dValid     <= 1'b0;
      memAddr    <= '0;
      memEnable  <= 1'b0;
      memWEnable <= 1'b0;
      memNewWord <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fReq || dReq) begin
            state      <= ISSUE;
            winner     <= pick_c;
            memEnable  <= 1'b1;
            memAddr    <= (pick_c == PORT_D) ? dAddr : fAddr;
            memWEnable <= (pick_c == PORT_D) && dWe;
            memNewWord <= (pick_c == PORT_D) ? dWdata : '0;
            fGnt       <= (pick_c == PORT_F);
            dGnt       <= (pick_c == PORT_D);
          end
        end
        ISSUE: begin
          last_win   <= winner;
          memEnable  <= 1'b0;
          memWEnable <= 1'b0;
          fGnt       <= 1'b0;
          dGnt       <= 1'b0;
          if (memWEnable) begin
            state <= IDLE;
          end else begin
            state  <= RESP;
            fValid <= (winner == PORT_F);
            dValid <= (winner == PORT_D);
          end
        end
        RESP: begin
          fValid <= 1'b0;
          dValid <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Read data is steered straight from the memory to the port being answered
  assign fData = fValid ? memWordOut : '0;
  assign dData = dValid ? memWordOut : '0;

endmodule
